// File: rtl/instr_fetch_unit_if.sv
// Bus-side and decoder-side signals of the instruction fetch stage.
// The master modport is the fetch unit; the slave modport is the RAM/arbiter/decoder side.
interface instr_fetch_unit_if #(
    parameter int ADDRESS_BUS_WIDTH = 13,
    parameter int DATA_BUS_WIDTH    = 32
) ();

    logic [ADDRESS_BUS_WIDTH-1:0] mem_address;
    logic                         mem_read_not_write;
    logic                         mem_req;
    logic                         mem_grant;
    logic [DATA_BUS_WIDTH-1:0]    mem_data;

    logic                         redirect_valid;
    logic [ADDRESS_BUS_WIDTH-1:0] redirect_addr;

    logic                         instr_ready;
    logic                         instr_valid;
    logic [DATA_BUS_WIDTH-1:0]    instr_word;
    logic [DATA_BUS_WIDTH-1:0]    instr_imm;
    logic [ADDRESS_BUS_WIDTH-1:0] instr_pc;

    modport master (
        output mem_address,
        output mem_read_not_write,
        output mem_req,
        input  mem_grant,
        input  mem_data,
        input  redirect_valid,
        input  redirect_addr,
        input  instr_ready,
        output instr_valid,
        output instr_word,
        output instr_imm,
        output instr_pc
    );

    modport slave (
        input  mem_address,
        input  mem_read_not_write,
        input  mem_req,
        output mem_grant,
        output mem_data,
        output redirect_valid,
        output redirect_addr,
        output instr_ready,
        input  instr_valid,
        input  instr_word,
        input  instr_imm,
        input  instr_pc
    );

endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: reads the opcode word at PC and the immediate at PC+2 from the
// shared synchronous-read RAM, then holds them for the decoder under a valid/ready handshake.
module instr_fetch_unit #(
    parameter int          ADDRESS_BUS_WIDTH = 13,
    parameter int          DATA_BUS_WIDTH    = 32,
    parameter int unsigned RESET_ADDRESS     = 4096
) (
    input  logic               clk,
    input  logic               reset_n,
    instr_fetch_unit_if.master fetch_bus
);

    localparam logic [ADDRESS_BUS_WIDTH-1:0] ResetPc  = ADDRESS_BUS_WIDTH'(RESET_ADDRESS);
    localparam logic [ADDRESS_BUS_WIDTH-1:0] WordMask = ~ADDRESS_BUS_WIDTH'(3);

    typedef enum logic [1:0] {
        FETCH_OP,
        FETCH_IMM,
        CAPTURE_IMM,
        HOLD
    } state_e;

    state_e                       state_q, state_d;
    logic [ADDRESS_BUS_WIDTH-1:0] pc_q, pc_d;
    logic [ADDRESS_BUS_WIDTH-1:0] pc_plus2;
    logic [ADDRESS_BUS_WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic [DATA_BUS_WIDTH-1:0]    instr_word_q, instr_word_d;
    logic [DATA_BUS_WIDTH-1:0]    instr_imm_q, instr_imm_d;
    logic                         instr_valid_q, instr_valid_d;

    assign pc_plus2 = pc_q + ADDRESS_BUS_WIDTH'(2);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= FETCH_OP;
        end else begin
            state_q <= state_d;
        end
    end

    // A redirect restarts the fetch from any state, abandoning a partly read instruction.
    always_comb begin
        state_d = state_q;
        if (fetch_bus.redirect_valid) begin
            state_d = FETCH_OP;
        end else begin
            case (state_q)
                FETCH_OP:    if (fetch_bus.mem_grant) state_d = FETCH_IMM;
                FETCH_IMM:   state_d = CAPTURE_IMM;
                CAPTURE_IMM: state_d = HOLD;
                HOLD:        if (fetch_bus.instr_ready) state_d = FETCH_OP;
                default:     state_d = FETCH_OP;
            endcase
        end
    end

    // The request is suppressed while reset is held so the arbiter sees an idle master.
    always_comb begin
        fetch_bus.mem_req     = 1'b0;
        fetch_bus.mem_address = pc_q;
        if (reset_n) begin
            case (state_q)
                FETCH_OP: begin
                    fetch_bus.mem_req = 1'b1;
                end
                FETCH_IMM, CAPTURE_IMM: begin
                    fetch_bus.mem_req     = 1'b1;
                    fetch_bus.mem_address = pc_plus2;
                end
                default: begin
                    fetch_bus.mem_req = 1'b0;
                end
            endcase
        end
    end

    assign fetch_bus.mem_read_not_write = 1'b1;
    assign fetch_bus.instr_valid        = instr_valid_q;
    assign fetch_bus.instr_word         = instr_word_q;
    assign fetch_bus.instr_imm          = instr_imm_q;
    assign fetch_bus.instr_pc           = instr_pc_q;

    // RAM data lags the address by one edge: the opcode arrives in FETCH_IMM, the immediate in CAPTURE_IMM.
    always_comb begin
        pc_d          = pc_q;
        instr_pc_d    = instr_pc_q;
        instr_word_d  = instr_word_q;
        instr_imm_d   = instr_imm_q;
        instr_valid_d = instr_valid_q;
        if (fetch_bus.redirect_valid) begin
            pc_d          = fetch_bus.redirect_addr & WordMask;
            instr_valid_d = 1'b0;
        end else begin
            case (state_q)
                FETCH_IMM: begin
                    instr_word_d = fetch_bus.mem_data;
                end
                CAPTURE_IMM: begin
                    instr_imm_d   = fetch_bus.mem_data;
                    instr_pc_d    = pc_q;
                    instr_valid_d = 1'b1;
                end
                HOLD: begin
                    if (fetch_bus.instr_ready) begin
                        instr_valid_d = 1'b0;
                        pc_d          = pc_q + ADDRESS_BUS_WIDTH'(4);
                    end
                end
                default: begin
                    pc_d = pc_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q          <= ResetPc;
            instr_pc_q    <= ResetPc;
            instr_word_q  <= '0;
            instr_imm_q   <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            instr_pc_q    <= instr_pc_d;
            instr_word_q  <= instr_word_d;
            instr_imm_q   <= instr_imm_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    // The presented instruction exists exactly while the FSM waits in HOLD.
    assert property (@(posedge clk) disable iff (!reset_n) instr_valid_q == (state_q == HOLD));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized grant/ready/redirect
// traffic compared against a program-counter level model of the fetch stage.
module tb_instr_fetch_unit;

    localparam int AW = 13;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [DW-1:0] ram [8192];

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.ADDRESS_BUS_WIDTH(AW), .DATA_BUS_WIDTH(DW)) bus ();

    instr_fetch_unit #(
        .ADDRESS_BUS_WIDTH(AW),
        .DATA_BUS_WIDTH(DW),
        .RESET_ADDRESS(4096)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .fetch_bus(bus)
    );

    // Single-port RAM with a registered read port.
    always @(posedge clk) bus.mem_data <= ram[bus.mem_address];

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr = '0;
        bus.instr_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_valid(input int limit, output int cycles);
        cycles = 0;
        while (bus.instr_valid !== 1'b1 && cycles < limit) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        int c;
        logic [AW-1:0] p;
        ram[4096] = 32'h88;
        ram[4098] = 32'h10;
        bus.mem_grant = 1'b1;
        apply_reset();
        checks++;
        if ({bus.instr_valid, bus.mem_req, bus.mem_read_not_write, bus.instr_pc, bus.mem_address, bus.instr_word, bus.instr_imm}
            !== {1'b0, 1'b0, 1'b1, 13'd4096, 13'd4096, 32'd0, 32'd0}) begin
            errors++;
            $display("[TB] FAIL reset_values: valid=%b req=%b rnw=%b pc=%0d addr=%0d word=%h imm=%h, required 0 0 1 4096 4096 0 0",
                     bus.instr_valid, bus.mem_req, bus.mem_read_not_write, bus.instr_pc, bus.mem_address, bus.instr_word, bus.instr_imm);
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if ({bus.mem_req, bus.mem_address} !== {1'b1, 13'd4096}) begin
            errors++;
            $display("[TB] FAIL req_after_release: req=%b addr=%0d, required 1 4096", bus.mem_req, bus.mem_address);
        end
        wait_valid(10, c);
        checks++;
        if (c !== 3) begin
            errors++;
            $display("[TB] FAIL first_latency: valid after %0d cycles, required 3", c);
        end
        checks++;
        if ({bus.instr_pc, bus.instr_word, bus.instr_imm} !== {13'd4096, 32'h88, 32'h10}) begin
            errors++;
            $display("[TB] FAIL first_instr: pc=%0d word=%h imm=%h, required 4096 00000088 00000010",
                     bus.instr_pc, bus.instr_word, bus.instr_imm);
        end
        p = bus.instr_pc;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({bus.instr_valid, bus.mem_req, bus.instr_pc, bus.instr_word, bus.instr_imm} !== {1'b1, 1'b0, p, 32'h88, 32'h10}) begin
                errors++;
                $display("[TB] FAIL hold_stable: valid=%b req=%b pc=%0d word=%h imm=%h, required 1 0 4096 00000088 00000010",
                         bus.instr_valid, bus.mem_req, bus.instr_pc, bus.instr_word, bus.instr_imm);
            end
        end
    endtask

    task automatic test_stream();
        int got = 0;
        int last = 0;
        logic [AW-1:0] e;
        apply_reset();
        bus.mem_grant = 1'b1;
        bus.instr_ready = 1'b1;
        reset_n = 1'b1;
        for (int cyc = 1; cyc <= 60 && got < 10; cyc++) begin
            @(negedge clk);
            if (bus.instr_valid === 1'b1) begin
                e = AW'(4096 + 4 * got);
                checks++;
                if ({bus.instr_pc, bus.instr_word, bus.instr_imm} !== {e, ram[e], ram[e + AW'(2)]}) begin
                    errors++;
                    $display("[TB] FAIL stream_instr: pc=%0d word=%h imm=%h, required %0d %h %h",
                             bus.instr_pc, bus.instr_word, bus.instr_imm, e, ram[e], ram[e + AW'(2)]);
                end
                checks++;
                if ((got == 0 && cyc != 3) || (got > 0 && cyc - last != 4)) begin
                    errors++;
                    $display("[TB] FAIL stream_spacing: instr %0d at cycle %0d, previous %0d, required first at 3 then every 4",
                             got, cyc, last);
                end
                last = cyc;
                got++;
            end
        end
        checks++;
        if (got != 10) begin
            errors++;
            $display("[TB] FAIL stream_count: %0d instructions, required 10", got);
        end
        bus.instr_ready = 1'b0;
    endtask

    task automatic test_grant_stall();
        int c;
        apply_reset();
        bus.mem_grant = 1'b0;
        reset_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if ({bus.mem_req, bus.mem_address, bus.instr_valid, bus.instr_word} !== {1'b1, 13'd4096, 1'b0, 32'd0}) begin
                errors++;
                $display("[TB] FAIL grant_stall: req=%b addr=%0d valid=%b word=%h, required 1 4096 0 0",
                         bus.mem_req, bus.mem_address, bus.instr_valid, bus.instr_word);
            end
        end
        bus.mem_grant = 1'b1;
        wait_valid(10, c);
        checks++;
        if (c !== 3) begin
            errors++;
            $display("[TB] FAIL grant_latency: valid after %0d cycles, required 3", c);
        end
        checks++;
        if ({bus.instr_pc, bus.instr_word, bus.instr_imm} !== {13'd4096, ram[4096], ram[4098]}) begin
            errors++;
            $display("[TB] FAIL grant_instr: pc=%0d word=%h imm=%h, required 4096 %h %h",
                     bus.instr_pc, bus.instr_word, bus.instr_imm, ram[4096], ram[4098]);
        end
    endtask

    task automatic test_redirect_capture();
        int c;
        ram[4124] = 32'h1D2;
        ram[4126] = 32'h1;
        apply_reset();
        bus.mem_grant = 1'b1;
        reset_n = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_addr = 13'd4132;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        checks++;
        if (bus.mem_address !== 13'd4132) begin
            errors++;
            $display("[TB] FAIL redirect_fetch_op: addr=%0d, required 4132", bus.mem_address);
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.mem_req, bus.mem_address, bus.instr_valid} !== {1'b1, 13'd4134, 1'b0}) begin
            errors++;
            $display("[TB] FAIL capture_phase: req=%b addr=%0d valid=%b, required 1 4134 0",
                     bus.mem_req, bus.mem_address, bus.instr_valid);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_addr = 13'd4126;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        checks++;
        if ({bus.instr_valid, bus.mem_req, bus.mem_address} !== {1'b0, 1'b1, 13'd4124}) begin
            errors++;
            $display("[TB] FAIL redirect_discard: valid=%b req=%b addr=%0d, required 0 1 4124",
                     bus.instr_valid, bus.mem_req, bus.mem_address);
        end
        wait_valid(10, c);
        checks++;
        if ({c[3:0], bus.instr_pc, bus.instr_word, bus.instr_imm} !== {4'd3, 13'd4124, 32'h1D2, 32'h1}) begin
            errors++;
            $display("[TB] FAIL redirect_instr: cycles=%0d pc=%0d word=%h imm=%h, required 3 4124 000001d2 00000001",
                     c, bus.instr_pc, bus.instr_word, bus.instr_imm);
        end
    endtask

    task automatic test_redirect_wrap();
        int c;
        bus.instr_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_addr = AW'(8188 + $urandom_range(0, 3));
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        bus.instr_ready = 1'b0;
        checks++;
        if ({bus.instr_valid, bus.mem_address} !== {1'b0, 13'd8188}) begin
            errors++;
            $display("[TB] FAIL redirect_beats_ready: valid=%b addr=%0d, required 0 8188", bus.instr_valid, bus.mem_address);
        end
        wait_valid(10, c);
        checks++;
        if ({c[3:0], bus.instr_pc, bus.instr_word, bus.instr_imm} !== {4'd3, 13'd8188, ram[8188], ram[8190]}) begin
            errors++;
            $display("[TB] FAIL top_instr: cycles=%0d pc=%0d word=%h imm=%h, required 3 8188 %h %h",
                     c, bus.instr_pc, bus.instr_word, bus.instr_imm, ram[8188], ram[8190]);
        end
        bus.instr_ready = 1'b1;
        @(negedge clk);
        bus.instr_ready = 1'b0;
        checks++;
        if ({bus.instr_valid, bus.mem_address} !== {1'b0, 13'd0}) begin
            errors++;
            $display("[TB] FAIL pc_wrap: valid=%b addr=%0d, required 0 0", bus.instr_valid, bus.mem_address);
        end
        wait_valid(10, c);
        checks++;
        if ({c[3:0], bus.instr_pc, bus.instr_word, bus.instr_imm} !== {4'd3, 13'd0, ram[0], ram[2]}) begin
            errors++;
            $display("[TB] FAIL wrap_instr: cycles=%0d pc=%0d word=%h imm=%h, required 3 0 %h %h",
                     c, bus.instr_pc, bus.instr_word, bus.instr_imm, ram[0], ram[2]);
        end
    endtask

    task automatic test_reset_mid_fetch();
        int c;
        apply_reset();
        bus.mem_grant = 1'b1;
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.mem_req, bus.mem_address} !== {1'b1, 13'd4098}) begin
            errors++;
            $display("[TB] FAIL fetch_imm_phase: req=%b addr=%0d, required 1 4098", bus.mem_req, bus.mem_address);
        end
        reset_n = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_addr = 13'd100;
        @(negedge clk);
        checks++;
        if ({bus.instr_valid, bus.mem_req, bus.instr_pc, bus.mem_address, bus.instr_word, bus.instr_imm}
            !== {1'b0, 1'b0, 13'd4096, 13'd4096, 32'd0, 32'd0}) begin
            errors++;
            $display("[TB] FAIL mid_fetch_reset: valid=%b req=%b pc=%0d addr=%0d word=%h imm=%h, required 0 0 4096 4096 0 0",
                     bus.instr_valid, bus.mem_req, bus.instr_pc, bus.mem_address, bus.instr_word, bus.instr_imm);
        end
        bus.redirect_valid = 1'b0;
        reset_n = 1'b1;
        wait_valid(10, c);
        checks++;
        if ({c[3:0], bus.instr_pc, bus.instr_word, bus.instr_imm} !== {4'd3, 13'd4096, ram[4096], ram[4098]}) begin
            errors++;
            $display("[TB] FAIL restart_instr: cycles=%0d pc=%0d word=%h imm=%h, required 3 4096 %h %h",
                     c, bus.instr_pc, bus.instr_word, bus.instr_imm, ram[4096], ram[4098]);
        end
    endtask

    // Model: the next presented instruction is always the one at exp_pc, which advances by 4 on
    // acceptance and jumps to the aligned target on a redirect.
    task automatic test_random_traffic();
        logic [AW-1:0]        exp_pc = 13'd4096;
        logic [AW+2*DW-1:0]   prev_fields = '0;
        logic [AW+2*DW-1:0]   cur_fields;
        logic                 prev_valid = 1'b0;
        logic                 prev_ready = 1'b0;
        logic                 prev_redir = 1'b0;
        logic                 owned = 1'b0;
        int                   presented = 0;
        apply_reset();
        bus.mem_grant = 1'b0;
        reset_n = 1'b1;
        repeat (3000) begin
            cur_fields = {bus.instr_pc, bus.instr_word, bus.instr_imm};
            if (prev_redir) begin
                checks++;
                if (bus.instr_valid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL rand_redirect_drop: valid=%b, required 0", bus.instr_valid);
                end
            end else if (prev_valid && !prev_ready) begin
                checks++;
                if ({bus.instr_valid, cur_fields} !== {1'b1, prev_fields}) begin
                    errors++;
                    $display("[TB] FAIL rand_hold: valid=%b fields=%h, required 1 %h", bus.instr_valid, cur_fields, prev_fields);
                end
            end
            if (bus.instr_valid === 1'b1 && !prev_valid) begin
                presented++;
                checks++;
                if (cur_fields !== {exp_pc, ram[exp_pc], ram[exp_pc + AW'(2)]}) begin
                    errors++;
                    $display("[TB] FAIL rand_instr: pc=%0d word=%h imm=%h, required %0d %h %h",
                             bus.instr_pc, bus.instr_word, bus.instr_imm, exp_pc, ram[exp_pc], ram[exp_pc + AW'(2)]);
                end
            end
            if (bus.mem_req === 1'b1 && bus.mem_grant === 1'b1) owned = 1'b1;
            else if (bus.mem_req !== 1'b1) owned = 1'b0;
            bus.redirect_valid = ($urandom_range(0, 15) == 0);
            bus.redirect_addr = AW'($urandom);
            bus.instr_ready = 1'($urandom_range(0, 1));
            bus.mem_grant = owned ? 1'b1 : 1'($urandom_range(0, 1));
            prev_valid = (bus.instr_valid === 1'b1);
            prev_ready = bus.instr_ready;
            prev_redir = bus.redirect_valid;
            prev_fields = cur_fields;
            if (bus.redirect_valid) exp_pc = bus.redirect_addr & ~AW'(3);
            else if (prev_valid && bus.instr_ready) exp_pc = exp_pc + AW'(4);
            @(negedge clk);
        end
        bus.redirect_valid = 1'b0;
        bus.instr_ready = 1'b0;
        checks++;
        if (presented < 50) begin
            errors++;
            $display("[TB] FAIL rand_progress: %0d instructions presented, required at least 50", presented);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, required completion before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.mem_grant = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr = '0;
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 8192; i++) ram[i] = $urandom;
        test_reset();
        test_stream();
        test_grant_stall();
        test_redirect_capture();
        test_redirect_wrap();
        test_reset_mid_fetch();
        test_random_traffic();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage of the multicycle computer, directly upstream of the decoder and a bus master on the shared single-port RAM. Each instruction occupies two RAM words: the opcode word at PC and the immediate word at PC+2. Instructions are laid out on a stride of 4. The block reads both words using the RAM's one-cycle synchronous read, then presents them to the decoder with a valid/ready handshake. It also accepts branch redirects from the execute stage.

## Interface
Parameters:
- ADDRESS_BUS_WIDTH, 13: RAM address width; 8192 words.
- DATA_BUS_WIDTH, 32: RAM word width.
- RESET_ADDRESS, 4096: reset vector, the halfway point of memory.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset. Sampled on the rising edge of clk.
- mem_address  out  ADDRESS_BUS_WIDTH  RAM address while owning the bus.
- mem_read_not_write  out  1  constant 1; this block never writes.
- mem_req  out  1  bus request to the arbiter.
- mem_grant  in  1  bus grant from the arbiter.
- mem_data  in  DATA_BUS_WIDTH  RAM data bus, read side.
- redirect_valid  in  1  branch taken; one-cycle pulse.
- redirect_addr  in  ADDRESS_BUS_WIDTH  branch target address.
- instr_ready  in  1  decoder accepts the current instruction.
- instr_valid  out  1  instr_word, instr_imm and instr_pc are valid.
- instr_word  out  DATA_BUS_WIDTH  opcode word, read from PC.
- instr_imm  out  DATA_BUS_WIDTH  immediate word, read from PC+2.
- instr_pc  out  ADDRESS_BUS_WIDTH  address of the presented instruction.

## Operation
- PC register: redirect_addr bits [1:0] are forced to 00 when loaded. Increment is +4, modulo 2^ADDRESS_BUS_WIDTH, so the top address 8188 wraps to 0.
- States:
  - FETCH_OP: mem_address = PC, mem_req = 1. If mem_grant = 1, go to FETCH_IMM; otherwise stay.
  - FETCH_IMM: mem_address = PC+2, mem_req = 1. On the edge, instr_word <= mem_data. Go to CAPTURE_IMM.
  - CAPTURE_IMM: mem_address = PC+2, mem_req = 1. On the edge, instr_imm <= mem_data, instr_pc <= PC, instr_valid <= 1. Go to HOLD.
  - HOLD: mem_req = 0, instr_valid = 1. If instr_ready = 1: instr_valid <= 0, PC <= PC+4, go to FETCH_OP.
- Bus ownership:
  - mem_grant is sampled only in FETCH_OP.
  - Once the grant is sampled high, the block owns the bus through CAPTURE_IMM. mem_req stays high for those states.
  - The arbiter contract: it must not revoke the grant while mem_req is high after granting.
- Redirect has the highest priority after reset, in any state:
  - PC <= redirect_addr & ~3, instr_valid <= 0, next state FETCH_OP.
  - Any partially captured words are discarded.
- Redirect and instr_ready in the same HOLD cycle: the redirect wins. PC becomes the target, not PC+4. The held instruction counts as consumed.
- mem_read_not_write is tied to 1. Outside FETCH_OP, FETCH_IMM and CAPTURE_IMM, mem_address holds PC.

## Timing
- Reset values (reset_n = 0 at an edge):
  - State = FETCH_OP, PC = RESET_ADDRESS.
  - instr_valid = 0, instr_word = 0, instr_imm = 0, instr_pc = RESET_ADDRESS.
  - mem_req = 0, mem_address = RESET_ADDRESS.
  - mem_req rises in the first cycle with reset_n = 1.
- Reset asserted mid-fetch overrides everything, including redirect. The in-flight transaction is abandoned; the RAM read result is ignored.
- Latency: grant sampled at edge E0, so opcode captured at E1, immediate captured at E2, and instr_valid is high after E2.
- Best-case throughput is one instruction per 4 cycles, with instr_ready held high and the grant immediate.
- mem_data is always captured exactly one edge after the corresponding address was driven, matching the RAM's registered read.
- instr_word, instr_imm and instr_pc are stable while instr_valid = 1. They change only in CAPTURE_IMM, FETCH_IMM or on reset.
- instr_valid never drops without instr_ready, redirect, or reset.

## Test plan
- Reset then release, grant tied high, RAM[4096] = 0x88, RAM[4098] = 0x10 -> instr_valid rises 3 cycles after release with instr_word = 0x00000088, instr_imm = 0x10, instr_pc = 4096.
- instr_ready held high, RAM program at 4096..4135 -> instr_pc sequence 4096, 4100, 4104, …, 4132, one instruction every 4 cycles, all words match.
- mem_grant low for 5 cycles in FETCH_OP -> mem_req stays high, mem_address = PC, no capture. Fetch completes 3 cycles after the grant rises.
- redirect_valid with redirect_addr = 4126 during CAPTURE_IMM of PC = 4132 -> instr_valid stays 0. The next fetch is from 4124, presenting RAM[4124] = 0x1D2 and RAM[4126] = 0x1.
- Redirect to 8188, then instr_ready -> next instr_pc = 0 (wrap), with words RAM[0] and RAM[2].
- reset_n low during FETCH_IMM -> next cycle all outputs at reset values. After release, the fetch restarts at 4096.
